// File: rtl/chunked_magnitude_comparator.sv
// Sequential magnitude comparator: walks two WIDTH-bit operands MSB-first,
// CHUNK bits per clock, stopping at the first differing chunk.
module chunked_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [WIDTH-1:0]                     a,
    input  logic [WIDTH-1:0]                     b,
    input  logic                                 signed_mode,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 a_less_b,
    output logic                                 a_equal_b,
    output logic                                 a_greater_b,
    output logic [$clog2(WIDTH/CHUNK + 1)-1:0]   cycles_used
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] sign_mask;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_gt;
    logic             chunk_lt;
    logic             accept;

    // Flipping the sign bit of both operands turns two's-complement order
    // into unsigned order, so the chunk datapath below is unsigned only.
    assign sign_mask = {signed_mode, {(WIDTH-1){1'b0}}};

    assign a_chunk  = a_q[idx*CHUNK +: CHUNK];
    assign b_chunk  = b_q[idx*CHUNK +: CHUNK];
    assign chunk_gt = (a_chunk > b_chunk);
    assign chunk_lt = (a_chunk < b_chunk);

    assign busy = (state == COMPARE);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first; a missing
    // branch would otherwise infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (chunk_gt || chunk_lt || (idx == '0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = COMPARE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: operand registers are reset too, so an aborted compare leaves
    // no stale operand state behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            idx         <= '0;
            a_less_b    <= 1'b0;
            a_equal_b   <= 1'b0;
            a_greater_b <= 1'b0;
            cycles_used <= '0;
        end else if (accept) begin
            a_q         <= a ^ sign_mask;
            b_q         <= b ^ sign_mask;
            idx         <= LAST_IDX;
            a_less_b    <= 1'b0;
            a_equal_b   <= 1'b0;
            a_greater_b <= 1'b0;
            cycles_used <= '0;
        end else if (state == COMPARE) begin
            cycles_used <= cycles_used + CW'(1);
            if (chunk_gt) begin
                a_greater_b <= 1'b1;
            end else if (chunk_lt) begin
                a_less_b <= 1'b1;
            end else if (idx == '0) begin
                a_equal_b <= 1'b1;
            end else begin
                idx <= idx - IW'(1);
            end
        end
    end

endmodule

// File: doc/chunked_magnitude_comparator.md
Name: chunked_magnitude_comparator

Overview:
- Parametrised, sequential successor of the team's 2-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, and terminates early on the first differing chunk.
- Supports unsigned and two's-complement signed comparison, selected per operation.
- Sits behind a start/done handshake, so wide compares can be time-shared without a wide combinational cone.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2.
- CHUNK, 2, bits compared per cycle; must divide WIDTH exactly. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a compare; accepted only when busy=0.
- a  input  WIDTH  operand A; sampled on the accepted start.
- b  input  WIDTH  operand B; sampled on the accepted start.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled on the accepted start.
- busy  output  1  high while a compare is in progress.
- done  output  1  single-cycle pulse; results are valid from this cycle onward.
- a_less_b  output  1  result, A < B.
- a_equal_b  output  1  result, A == B.
- a_greater_b  output  1  result, A > B.
- cycles_used  output  $clog2(NCHUNK+1)  number of chunks examined in the last compare.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE.
  - busy, done, a_less_b, a_equal_b, a_greater_b and cycles_used all reset to 0.
  - Operand registers and chunk index reset to 0.
- FSM states and transitions:
  - IDLE: start=1 latches a, b and signed_mode, clears all result flags and cycles_used, loads chunk index = NCHUNK-1, and moves to COMPARE.
  - Operand latch: if signed_mode=1, bit WIDTH-1 of both latched operands is inverted. This maps signed order onto unsigned order, so the datapath is unsigned-only.
  - COMPARE: busy=1. Each cycle compares chunk [idx*CHUNK +: CHUNK] of A against B and increments cycles_used.
    - If the chunks differ: set a_greater_b or a_less_b, go to DONE.
    - If equal and idx=0: set a_equal_b, go to DONE.
    - Otherwise: idx decrements, stay in COMPARE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 in this cycle is accepted exactly as in IDLE and goes straight to COMPARE (back-to-back operation).
    - Otherwise go to IDLE.
- Result flags:
  - Registered and one-hot whenever valid.
  - All three are 0 from an accepted start until the done cycle.
  - Held stable after done until the next accepted start.
- Latency, with start accepted at edge T0:
  - First differing chunk k (k=0 is the MSB chunk): done is high in cycle T0+k+2 and cycles_used = k+1.
  - Equal operands: done at T0+NCHUNK+1 and cycles_used = NCHUNK.
- Changes to a, b or signed_mode after acceptance have no effect.
- start while busy=1 is ignored: not queued, no error.
- Reset mid-COMPARE aborts immediately. No done pulse is produced and all outputs read 0.
- cycles_used never exceeds NCHUNK and never wraps.
- WIDTH=CHUNK (NCHUNK=1) is legal: single-cycle compare, done at T0+2.

Test Plan:
- WIDTH=8, CHUNK=2, unsigned, a=8'hA5, b=8'h25 -> MSB chunk differs; done at T0+2; a_greater_b=1, others 0; cycles_used=1.
- Unsigned, a=8'h3C, b=8'h3D -> only the LSB chunk differs; busy high 4 cycles; done at T0+5; a_less_b=1; cycles_used=4.
- a=b=8'h7E -> a_equal_b=1 at T0+5, cycles_used=4. Repeat with signed_mode=1 -> same result.
- Signed vs unsigned on the same operands, a=8'h80, b=8'h01:
  - signed_mode=1 -> a_less_b=1, cycles_used=1.
  - signed_mode=0 -> a_greater_b=1.
- Handshake:
  - start pulsed during COMPARE with new operands -> ignored; first result unchanged.
  - start held in the DONE cycle -> second compare accepted with no IDLE cycle; flags read 000 until its done.
- Reset mid-compare: rst_n low for 1 cycle during COMPARE -> busy, done and flags go 0 immediately with no done pulse; a following start completes normally.
- Exhaustive check: WIDTH=4, CHUNK=1, all 256 pairs x both modes vs a behavioural model.
  - Flags must be one-hot at every done.
  - cycles_used must equal 1 + the index of the first differing bit from the MSB, or 4 when the operands are equal.
